// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and sequencing controller for the 5-stage RV32I pipeline.
//   It produces the per-stage stall/flush controls and the EX-stage operand
//   forwarding selects. It also runs the variable-latency data-memory
//   handshake for the instruction in M, including timeout detection.
//   The block holds no datapath storage.
//
// Ports
//   i_clk, i_rst                 clock (rising edge), synchronous active-high reset
//   rs1_addrD, rs2_addrD         decode-stage source registers
//   rs1_addrE, rs2_addrE         execute-stage source registers
//   rd_addrE/M/W, rd_wrenE/M/W   destination register and write enable per stage
//   wb_selE, wb_selM             write-back select (2'b01 = load)
//   mem_wrenM                    store size in M (nonzero = store)
//   pc_selE                      control transfer taken in E
//   i_dmem_ack                   data memory completes the access this cycle
//   o_dmem_req                   data memory request for the M instruction
//   StallF/D/E/M                 hold PC, IF/ID, ID/EX, EX/MEM
//   FlushD/E/W                   bubble IF/ID, ID/EX, MEM/WB
//   ForwardAE, ForwardBE         00 regfile, 10 M result, 01 W result
//   o_mem_err                    sticky memory-timeout flag
module pipeline_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [4:0] rs1_addrD,
    input  logic [4:0] rs2_addrD,
    input  logic [4:0] rs1_addrE,
    input  logic [4:0] rs2_addrE,
    input  logic [4:0] rd_addrE,
    input  logic [4:0] rd_addrM,
    input  logic [4:0] rd_addrW,
    input  logic       rd_wrenE,
    input  logic       rd_wrenM,
    input  logic       rd_wrenW,
    input  logic [1:0] wb_selE,
    input  logic [1:0] wb_selM,
    input  logic [1:0] mem_wrenM,
    input  logic       pc_selE,
    input  logic       i_dmem_ack,
    output logic       o_dmem_req,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       o_mem_err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          mem_err;

    logic memacc;
    logic mstall;
    logic load_use;

    assign memacc     = (wb_selM == 2'b01) || (mem_wrenM != 2'b00);
    assign o_dmem_req = memacc && (state != ST_ERR) && !i_rst;
    assign mstall     = (o_dmem_req && !i_dmem_ack) || (state == ST_ERR);
    assign load_use   = (wb_selE == 2'b01) && rd_wrenE && (rd_addrE != 5'd0) &&
                        ((rd_addrE == rs1_addrD) || (rd_addrE == rs2_addrD));
    assign o_mem_err  = mem_err;

    // Memory handshake FSM. cnt holds the number of un-acked request cycles
    // seen so far for the current access.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            mem_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mstall) begin
                        state <= ST_WAIT;
                        cnt   <= CW'(1);
                    end
                end
                ST_WAIT: begin
                    // A vanished access while M is held cannot happen in a
                    // well-formed pipeline; it is handled like an ack.
                    if (i_dmem_ack || !memacc) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (cnt + CW'(1) == CW'(TIMEOUT)) begin
                        state   <= ST_ERR;
                        mem_err <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_ERR: begin
                    state <= ST_ERR;
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Stall/flush priority: memory stall, then taken transfer, then load-use.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (!i_rst) begin
            if (mstall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (pc_selE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rdm,
        input logic       wrenm,
        input logic [4:0] rdw,
        input logic       wrenw
    );
        if (wrenm && (rdm != 5'd0) && (rdm == rs)) begin
            return 2'b10;
        end else if (wrenw && (rdw != 5'd0) && (rdw == rs)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    always_comb begin
        ForwardAE = fwd_sel(rs1_addrE, rd_addrM, rd_wrenM, rd_addrW, rd_wrenW);
        ForwardBE = fwd_sel(rs2_addrE, rd_addrM, rd_wrenM, rd_addrW, rd_wrenW);
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (TIMEOUT overridden to 4).
// Output vector layout: {req, StallF, StallD, StallE, StallM,
//                        FlushD, FlushE, FlushW, ForwardAE, ForwardBE, mem_err}
module tb_pipeline_hazard_ctrl;

    localparam int unsigned TO = 4;

    typedef struct packed {
        logic [4:0] rs1D;
        logic [4:0] rs2D;
        logic [4:0] rs1E;
        logic [4:0] rs2E;
        logic [4:0] rdE;
        logic [4:0] rdM;
        logic [4:0] rdW;
        logic       wrenE;
        logic       wrenM;
        logic       wrenW;
        logic [1:0] wbselE;
        logic [1:0] wbselM;
        logic [1:0] memwrM;
        logic       pcsel;
        logic       ack;
    } in_t;

    typedef struct {
        string       name;
        in_t         stim;
        logic [12:0] exp;
    } rec_t;

    localparam logic [12:0] ZERO = 13'b0_0000_000_00_00_0;
    localparam logic [12:0] LU   = 13'b0_1100_010_00_00_0;
    localparam logic [12:0] BR   = 13'b0_0000_110_00_00_0;
    localparam logic [12:0] MST  = 13'b1_1111_001_00_00_0;
    localparam logic [12:0] ERRV = 13'b0_1111_001_00_00_1;
    localparam logic [12:0] REQ  = 13'b1_0000_000_00_00_0;
    localparam logic [12:0] FA10 = 13'b0_0000_000_10_00_0;
    localparam logic [12:0] FA01 = 13'b0_0000_000_01_00_0;
    localparam logic [12:0] FB10 = 13'b0_0000_000_00_10_0;
    localparam logic [12:0] FB01 = 13'b0_0000_000_00_01_0;
    localparam logic [12:0] ERRF = 13'b0_0000_000_00_00_1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    in_t  cur = '0;

    logic       o_dmem_req, StallF, StallD, StallE, StallM;
    logic       FlushD, FlushE, FlushW, o_mem_err;
    logic [1:0] ForwardAE, ForwardBE;

    int checks   = 0;
    int failures = 0;

    // Reference: an error flag plus a count of consecutive un-acked request cycles.
    logic m_err  = 1'b0;
    int   m_pend = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.TIMEOUT(TO)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .rs1_addrD  (cur.rs1D),
        .rs2_addrD  (cur.rs2D),
        .rs1_addrE  (cur.rs1E),
        .rs2_addrE  (cur.rs2E),
        .rd_addrE   (cur.rdE),
        .rd_addrM   (cur.rdM),
        .rd_addrW   (cur.rdW),
        .rd_wrenE   (cur.wrenE),
        .rd_wrenM   (cur.wrenM),
        .rd_wrenW   (cur.wrenW),
        .wb_selE    (cur.wbselE),
        .wb_selM    (cur.wbselM),
        .mem_wrenM  (cur.memwrM),
        .pc_selE    (cur.pcsel),
        .i_dmem_ack (cur.ack),
        .o_dmem_req (o_dmem_req),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .StallM     (StallM),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .FlushW     (FlushW),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .o_mem_err  (o_mem_err)
    );

    always @(posedge clk) begin
        logic busy;
        int   np;
        logic ne;
        busy = ((cur.wbselM == 2'b01) || (cur.memwrM != 2'b00)) && !cur.ack;
        np = m_pend;
        ne = m_err;
        if (rst) begin
            np = 0;
            ne = 1'b0;
        end else if (!m_err) begin
            if (busy) begin
                np = m_pend + 1;
                if (np >= int'(TO)) ne = 1'b1;
            end else begin
                np = 0;
            end
        end
        m_pend <= np;
        m_err  <= ne;
    end

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input in_t v);
        if (v.wrenM && v.rdM != 0 && v.rdM == rs) return 2'b10;
        if (v.wrenW && v.rdW != 0 && v.rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [12:0] ref_out(input in_t v, input logic r, input logic err);
        logic       memacc, req, mst, lu;
        logic [6:0] ctl;
        memacc = (v.wbselM == 2'b01) || (v.memwrM != 2'b00);
        req    = memacc && !err && !r;
        mst    = (req && !v.ack) || err;
        lu     = (v.wbselE == 2'b01) && v.wrenE && v.rdE != 0 &&
                 (v.rdE == v.rs1D || v.rdE == v.rs2D);
        ctl = 7'b0;
        if (!r) begin
            if (mst)          ctl = 7'b1111_001;
            else if (v.pcsel) ctl = 7'b0000_110;
            else if (lu)      ctl = 7'b1100_010;
        end
        return {req, ctl, ref_fwd(v.rs1E, v), ref_fwd(v.rs2E, v), err};
    endfunction

    task automatic check(input string name, input logic [12:0] exp);
        logic [12:0] got;
        got = {o_dmem_req, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushW, ForwardAE, ForwardBE, o_mem_err};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    // Drive just after a rising edge, compare at the following falling edge.
    task automatic step(input in_t v, input logic r, input string name, input logic [12:0] exp);
        @(posedge clk);
        #1;
        cur = v;
        rst = r;
        @(negedge clk);
        check(name, exp);
    endtask

    rec_t tbl[$];

    task automatic add(input string name, input in_t v, input logic [12:0] exp);
        rec_t r;
        r.name = name;
        r.stim = v;
        r.exp  = exp;
        tbl.push_back(r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t v, z, lu_v, st, st_ack, sp;
        z = '0;

        lu_v = '0;
        lu_v.wbselE = 2'b01; lu_v.wrenE = 1'b1; lu_v.rdE = 5'd5; lu_v.rs1D = 5'd5;

        st = '0;
        st.memwrM = 2'b01;
        st_ack = st;
        st_ack.ack = 1'b1;

        // Reset: controls gated, forwarding live.
        repeat (2) @(posedge clk);
        v = lu_v; v.rdM = 5'd3; v.wrenM = 1'b1; v.rs1E = 5'd3; v.memwrM = 2'b10;
        step(v, 1'b1, "rst_gating", FA10);
        step(z, 1'b0, "reset_state", ZERO);

        // Table of single-cycle vectors (controller stays idle throughout).
        add("all_zero", z, ZERO);
        add("lu_rs1", lu_v, LU);
        v = lu_v; v.rs1D = 5'd0; v.rs2D = 5'd5;             add("lu_rs2", v, LU);
        v = lu_v; v.rdE = 5'd0; v.rs1D = 5'd0;              add("lu_x0", v, ZERO);
        v = lu_v; v.wbselE = 2'b00;                         add("no_load", v, ZERO);
        v = lu_v; v.wrenE = 1'b0;                           add("lu_nowren", v, ZERO);
        v = z; v.rdM = 5'd7; v.rdW = 5'd7; v.wrenM = 1'b1; v.wrenW = 1'b1; v.rs2E = 5'd7;
        add("fwdB_M_prio", v, FB10);
        v.rdM = 5'd0;                                       add("fwdB_W", v, FB01);
        v = z; v.wrenM = 1'b1; v.wrenW = 1'b1;              add("fwdA_x0", v, ZERO);
        v = z; v.rdM = 5'd7; v.rdW = 5'd7; v.wrenW = 1'b1; v.rs1E = 5'd7;
        add("fwdA_M_nowren", v, FA01);
        v = z; v.rdM = 5'd9; v.wrenM = 1'b1; v.rs1E = 5'd9; v.rs2E = 5'd9;
        add("fwd_both_M", v, 13'b0_0000_000_10_10_0);
        v = lu_v; v.pcsel = 1'b1;                           add("br_over_lu", v, BR);
        add("store_zero_wait", st_ack, REQ);
        v = z; v.wbselM = 2'b01; v.ack = 1'b1;              add("load_zero_wait", v, REQ);

        foreach (tbl[i]) step(tbl[i].stim, 1'b0, tbl[i].name, tbl[i].exp);

        // Load-use: one bubble, then W forwarding.
        step(lu_v, 1'b0, "lu_bubble", LU);
        v = z; v.rdW = 5'd5; v.wrenW = 1'b1; v.rs1E = 5'd5;
        step(v, 1'b0, "lu_fwd_W", FA01);

        // Wait states: ack on the 4th request cycle.
        step(st, 1'b0, "ws_1", MST);
        step(st, 1'b0, "ws_2", MST);
        step(st, 1'b0, "ws_3", MST);
        step(st_ack, 1'b0, "ws_ack", REQ);
        step(z, 1'b0, "ws_done", ZERO);

        // Timeout, sticky error, reset recovery.
        step(st, 1'b0, "to_1", MST);
        step(st, 1'b0, "to_2", MST);
        step(st, 1'b0, "to_3", MST);
        step(st, 1'b0, "to_4", MST);
        step(st, 1'b0, "to_err", ERRV);
        step(st_ack, 1'b0, "to_ack_ignored", ERRV);
        sp = lu_v; sp.pcsel = 1'b1;
        step(sp, 1'b0, "to_err_over_br", ERRV);
        step(st, 1'b1, "to_rst_cycle", ERRF);
        step(z, 1'b0, "to_after_rst", ZERO);

        // Mid-wait reset: the count must restart from zero.
        step(st, 1'b0, "mw_1", MST);
        step(st, 1'b0, "mw_2", MST);
        step(st, 1'b1, "mw_rst", ZERO);
        step(st, 1'b0, "mw_re1", MST);
        step(st, 1'b0, "mw_re2", MST);
        step(st, 1'b0, "mw_re3", MST);
        step(st_ack, 1'b0, "mw_ack", REQ);

        // Memory stall together with a taken branch.
        sp = st; sp.pcsel = 1'b1;
        step(sp, 1'b0, "ms_br_stall", MST);
        sp.ack = 1'b1;
        step(sp, 1'b0, "ms_br_release", REQ | BR);
        step(z, 1'b0, "ms_idle", ZERO);

        // Randomized traffic against the reference model.
        step(z, 1'b1, "rnd_rst", ZERO);
        for (int n = 0; n < 400; n++) begin
            logic r;
            v.rs1D   = 5'($urandom_range(0, 3));
            v.rs2D   = 5'($urandom_range(0, 3));
            v.rs1E   = 5'($urandom_range(0, 3));
            v.rs2E   = 5'($urandom_range(0, 3));
            v.rdE    = 5'($urandom_range(0, 3));
            v.rdM    = 5'($urandom_range(0, 3));
            v.rdW    = 5'($urandom_range(0, 3));
            v.wrenE  = 1'($urandom_range(0, 1));
            v.wrenM  = 1'($urandom_range(0, 1));
            v.wrenW  = 1'($urandom_range(0, 1));
            v.wbselE = 2'($urandom_range(0, 3));
            v.wbselM = 2'($urandom_range(0, 3));
            v.memwrM = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
            v.pcsel  = ($urandom_range(0, 3) == 0);
            v.ack    = ($urandom_range(0, 2) == 0);
            r        = ($urandom_range(0, 24) == 0);
            @(posedge clk);
            #1;
            cur = v;
            rst = r;
            @(negedge clk);
            check("random", ref_out(v, r, m_err));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage RV32I pipeline. It generates the per-stage stall and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the EX-stage operand forwarding selects. It also runs the variable-latency data-memory handshake for the access held in the EX/MEM register, with timeout detection. It sits beside the datapath and contains no datapath storage.

## Interface
- TIMEOUT, 16, consecutive un-acked request cycles before the access is declared failed; legal range 2..255.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous reset, active-high.
- rs1_addrD, rs2_addrD  in  5 each  source registers of the instruction in decode.
- rs1_addrE, rs2_addrE  in  5 each  source registers of the instruction in execute.
- rd_addrE, rd_addrM, rd_addrW  in  5 each  destination registers in E, M and W.
- rd_wrenE, rd_wrenM, rd_wrenW  in  1 each  register-write enables in E, M and W.
- wb_selE, wb_selM  in  2 each  write-back select; 2'b01 means load.
- mem_wrenM  in  2  store size; nonzero means store.
- pc_selE  in  1  control transfer taken in E (branch taken, jal, jalr).
- i_dmem_ack  in  1  data memory completes the current access this cycle.
- o_dmem_req  out  1  data memory access request for the M-stage instruction.
- StallF, StallD, StallE, StallM  out  1 each  hold the PC and the IF/ID, ID/EX and EX/MEM registers.
- FlushD, FlushE, FlushW  out  1 each  clear IF/ID, ID/EX and MEM/WB to a bubble.
- ForwardAE, ForwardBE  out  2 each  operand select: 00 register file, 10 M-stage result, 01 W-stage result.
- o_mem_err  out  1  sticky error flag: memory access timed out.

## Operation
- **Memory access.** memaccM = (wb_selM==2'b01) | (mem_wrenM!=0).
- **Request.** o_dmem_req = memaccM & state!=ERR & !i_rst (combinational).
- **Memory stall.** mstall = (o_dmem_req & !i_dmem_ack) | state==ERR.
- **FSM states:** IDLE, WAIT, ERR. cnt is ceil(log2(TIMEOUT+1)) bits wide.
  - IDLE: if mstall, go to WAIT with cnt=1. Otherwise stay in IDLE; a same-cycle ack is a zero-wait access.
  - WAIT: if i_dmem_ack, go to IDLE with cnt=0. Else if cnt+1==TIMEOUT, go to ERR and set o_mem_err. Else cnt=cnt+1.
  - WAIT with memaccM deasserted is illegal, because M is stalled. Treat it as an ack: return to IDLE.
  - ERR: absorbing until i_rst. Every stage is stalled, o_dmem_req=0, and i_dmem_ack is ignored.
- **Load-use hazard.** lu = (wb_selE==2'b01) & rd_wrenE & rd_addrE!=0 & (rd_addrE==rs1_addrD | rd_addrE==rs2_addrD).
- **Stall and flush priority (highest first):**
  1. mstall: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. Branch and load-use are ignored this cycle; they are re-evaluated once the stall releases.
  2. pc_selE: FlushD=FlushE=1 and all stalls 0, even if lu is also true.
  3. lu: StallF=StallD=1, FlushE=1, all others 0.
  4. Otherwise all stalls and flushes are 0.
- **Forwarding, source A** (B is identical using rs2_addrE):
  - 10 if rd_wrenM & rd_addrM!=0 & rd_addrM==rs1_addrE;
  - else 01 if rd_wrenW & rd_addrW!=0 & rd_addrW==rs1_addrE;
  - else 00.
  - M takes priority over W.
  - x0 is never forwarded.
  - Forwarding is independent of stalls.
- **Reset.** While i_rst is high, all stall and flush outputs and o_dmem_req are 0. ForwardAE and ForwardBE remain combinational.

## Timing
- Stall, flush, forward and o_dmem_req are combinational from the inputs and the registered state. They are valid in the same cycle.
- State, cnt and o_mem_err are registered. Reset values: IDLE, 0, 0.
- A reset edge during WAIT or ERR returns the block to IDLE with cnt=0 and o_mem_err=0.
- An access acked in cycle N: stalls are asserted from the request cycle through N-1 and deasserted in cycle N. The M instruction advances on the edge that ends cycle N.
- Timeout: with no ack, o_mem_err rises after the TIMEOUT-th edge following the first request cycle. The stall persists.
- A load-use hazard inserts exactly one bubble in E, then resolves through W forwarding (01).

## Test plan
- **Load-use.** lw x5 in E (wb_selE=01, rd_addrE=5), rs1_addrD=5 -> StallF=StallD=FlushE=1 for 1 cycle. Next cycle, with the load in W, ForwardAE=01.
- **Forward priority.** rd_addrM=rd_addrW=7 (both write-enabled), rs2_addrE=7 -> ForwardBE=10. With rd_addrM=0 -> ForwardBE=01. With rs1_addrE=0 -> ForwardAE=00.
- **Branch versus load-use.** pc_selE=1 while lu=1 -> FlushD=FlushE=1, StallF=StallD=0.
- **Wait states.** Store in M (mem_wrenM=01), ack on the 4th request cycle -> StallF..StallM=1 and FlushW=1 for 3 cycles, then 0. Zero-wait ack -> no stall at all.
- **Timeout.** TIMEOUT=4, no ack -> o_mem_err=1 after the 4th edge and o_dmem_req=0. A later ack has no effect. i_rst -> IDLE, o_mem_err=0.
- **Mid-wait reset and simultaneous events.** Assert i_rst in WAIT with cnt=2 -> outputs 0 and state IDLE on the next edge. Raise mstall together with pc_selE -> only the memory stall applies; the flush happens after the ack.
